// File: rtl/memory_read_pipe.sv
// SRAM read stage with credit-limited outstanding reads, in-order responses, stall and flush.
// Optional performance counters: define MEMORY_READ_PIPE_PERF_CNT_EN.
module memory_read_pipe #(
  parameter int PIPELINE_SLAVE_DATA_WIDTH  = 64,
  parameter int MEMORY_DATA_WIDTH          = 32,
  parameter int MEMORY_ADDR_WIDTH          = 32,
  parameter int ADDR_OFFSET                = 0,
  parameter int MAX_OUTSTANDING            = 4,
  parameter int PIPELINE_MASTER_DATA_WIDTH = MEMORY_DATA_WIDTH + PIPELINE_SLAVE_DATA_WIDTH
) (
  input  logic                                  clk_i,
  input  logic                                  rst_ni,
  input  logic                                  stall_i,
  input  logic                                  flush_i,
  input  logic [PIPELINE_SLAVE_DATA_WIDTH-1:0]  stage_slave_data,
  input  logic                                  stage_slave_valid,
  output logic                                  stage_slave_ready,
  output logic [PIPELINE_MASTER_DATA_WIDTH-1:0] stage_master_data,
  output logic                                  stage_master_valid,
  input  logic                                  stage_master_ready,
  output logic                                  memory_master_mem_req,
  input  logic                                  memory_master_mem_gnt,
  output logic [MEMORY_ADDR_WIDTH-1:0]          memory_master_mem_addr,
  output logic                                  memory_master_mem_we,
  output logic [MEMORY_DATA_WIDTH/8-1:0]        memory_master_mem_be,
  output logic [MEMORY_DATA_WIDTH-1:0]          memory_master_mem_wdata,
  input  logic                                  memory_master_mem_valid,
  input  logic [MEMORY_DATA_WIDTH-1:0]          memory_master_mem_rdata
`ifdef MEMORY_READ_PIPE_PERF_CNT_EN
  ,
  output logic [31:0]                           perf_issued_o,
  output logic [31:0]                           perf_credit_stall_o,
  output logic [31:0]                           perf_dropped_o
`endif
);

  localparam int SW = PIPELINE_SLAVE_DATA_WIDTH;
  localparam int MW = PIPELINE_MASTER_DATA_WIDTH;
  localparam int CW = $clog2(MAX_OUTSTANDING + 1);
  localparam int PW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam logic [CW:0]   MAX_U = (CW+1)'(MAX_OUTSTANDING);
  localparam logic [PW-1:0] LAST  = PW'(MAX_OUTSTANDING - 1);

  logic          reg_valid;
  logic [SW-1:0] reg_data;
  logic [CW-1:0] inflight, drop_cnt, resp_count;
  logic [CW:0]   used;
  logic [SW-1:0] ctx_mem [MAX_OUTSTANDING];
  logic [MW-1:0] resp_mem [MAX_OUTSTANDING];
  logic [PW-1:0] ctx_wr, ctx_rd, resp_wr, resp_rd;
  logic          issue, rsp_in, rsp_keep, resp_empty, bypass, resp_push, resp_pop;
  logic [MW-1:0] rsp_word;

  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == LAST) ? '0 : p + 1'b1;
  endfunction

  // Responses with nothing outstanding (e.g. after reset) carry no credit and are ignored.
  always_comb begin
    used       = {1'b0, inflight} + {1'b0, resp_count};
    memory_master_mem_req = reg_valid && !stall_i && !flush_i && (used < MAX_U);
    issue      = memory_master_mem_req && memory_master_mem_gnt;
    rsp_in     = memory_master_mem_valid && (inflight != '0);
    rsp_keep   = rsp_in && !flush_i && (drop_cnt == '0);
    resp_empty = (resp_count == '0);
    bypass     = rsp_keep && resp_empty && stage_master_ready;
    resp_push  = rsp_keep && !bypass;
    resp_pop   = !flush_i && !resp_empty && stage_master_ready;
    rsp_word   = {memory_master_mem_rdata, ctx_mem[ctx_rd]};
    stage_slave_ready  = !flush_i && (!reg_valid || issue);
    stage_master_valid = !flush_i && (!resp_empty || bypass);
    stage_master_data  = '0;
    if (!resp_empty)  stage_master_data = resp_mem[resp_rd];
    else if (bypass)  stage_master_data = rsp_word;
  end

  assign memory_master_mem_addr  = reg_data[ADDR_OFFSET +: MEMORY_ADDR_WIDTH];
  assign memory_master_mem_we    = 1'b0;
  assign memory_master_mem_be    = '0;
  assign memory_master_mem_wdata = '0;

  always_ff @(posedge clk_i) begin
    if (issue)     ctx_mem[ctx_wr]   <= stage_slave_data_q();
    if (resp_push) resp_mem[resp_wr] <= rsp_word;
  end

  function automatic logic [SW-1:0] stage_slave_data_q();
    return reg_data;
  endfunction

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      reg_valid  <= 1'b0;
      reg_data   <= '0;
      inflight   <= '0;
      drop_cnt   <= '0;
      resp_count <= '0;
      ctx_wr     <= '0;
      ctx_rd     <= '0;
      resp_wr    <= '0;
      resp_rd    <= '0;
    end else begin
      if (flush_i) begin
        reg_valid <= 1'b0;
        reg_data  <= '0;
      end else if (stage_slave_valid && stage_slave_ready) begin
        reg_valid <= 1'b1;
        reg_data  <= stage_slave_data;
      end else if (issue) begin
        reg_valid <= 1'b0;
      end

      if (issue)  ctx_wr <= nxt(ctx_wr);
      if (rsp_in) ctx_rd <= nxt(ctx_rd);
      case ({issue, rsp_in})
        2'b10:   inflight <= inflight + 1'b1;
        2'b01:   inflight <= inflight - 1'b1;
        default: inflight <= inflight;
      endcase

      // Everything still outstanding after the flush cycle must be swallowed on return.
      if (flush_i)                        drop_cnt <= inflight - CW'(rsp_in);
      else if (rsp_in && drop_cnt != '0)  drop_cnt <= drop_cnt - 1'b1;

      if (flush_i) begin
        resp_count <= '0;
        resp_wr    <= '0;
        resp_rd    <= '0;
      end else begin
        if (resp_push) resp_wr <= nxt(resp_wr);
        if (resp_pop)  resp_rd <= nxt(resp_rd);
        case ({resp_push, resp_pop})
          2'b10:   resp_count <= resp_count + 1'b1;
          2'b01:   resp_count <= resp_count - 1'b1;
          default: resp_count <= resp_count;
        endcase
      end
    end
  end

`ifdef MEMORY_READ_PIPE_PERF_CNT_EN
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      perf_issued_o       <= '0;
      perf_credit_stall_o <= '0;
      perf_dropped_o      <= '0;
    end else begin
      if (issue && perf_issued_o != '1)
        perf_issued_o <= perf_issued_o + 1'b1;
      if (reg_valid && used == MAX_U && perf_credit_stall_o != '1)
        perf_credit_stall_o <= perf_credit_stall_o + 1'b1;
      if (rsp_in && (flush_i || drop_cnt != '0) && perf_dropped_o != '1)
        perf_dropped_o <= perf_dropped_o + 1'b1;
    end
  end
`endif

  a_used_bound: assert property (@(posedge clk_i) disable iff (!rst_ni) used <= MAX_U);
  a_inflight_bound: assert property (@(posedge clk_i) disable iff (!rst_ni) {1'b0, inflight} <= MAX_U);
  a_drop_bound: assert property (@(posedge clk_i) disable iff (!rst_ni) {1'b0, drop_cnt} <= MAX_U);
  a_resp_overflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(resp_push && !resp_pop && {1'b0, resp_count} == MAX_U));

endmodule

// File: tb/tb_memory_read_pipe.sv
// Directed bench for memory_read_pipe: per-cycle vector table plus corner-case sequences.
module tb_memory_read_pipe;
  localparam int SW = 64, MD = 32, AW = 32, OW = 96;

  logic clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  logic          rst_ni, stall_i, flush_i;
  logic [SW-1:0] slave_data;
  logic          slave_valid, slave_ready;
  logic [OW-1:0] master_data;
  logic          master_valid, master_ready;
  logic          mem_req, mem_gnt, mem_we, mem_valid;
  logic [AW-1:0] mem_addr;
  logic [MD/8-1:0] mem_be;
  logic [MD-1:0] mem_wdata, mem_rdata;

  memory_read_pipe dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .stall_i(stall_i), .flush_i(flush_i),
    .stage_slave_data(slave_data), .stage_slave_valid(slave_valid), .stage_slave_ready(slave_ready),
    .stage_master_data(master_data), .stage_master_valid(master_valid), .stage_master_ready(master_ready),
    .memory_master_mem_req(mem_req), .memory_master_mem_gnt(mem_gnt), .memory_master_mem_addr(mem_addr),
    .memory_master_mem_we(mem_we), .memory_master_mem_be(mem_be), .memory_master_mem_wdata(mem_wdata),
    .memory_master_mem_valid(mem_valid), .memory_master_mem_rdata(mem_rdata));

  typedef struct { logic [AW-1:0] addr; int due; } mreq_t;
  typedef struct {
    bit in_valid; int in_tag;
    bit sready; bit req; logic [AW-1:0] addr; bit mvalid; logic [OW-1:0] mdata;
  } vec_t;

  mreq_t mq[$];
  logic [OW-1:0] obs_q[$], exp_q[$];
  int passed = 0, total = 0;
  int cyc = 0, lat = 1, feed_left = 0, next_tag = 0;
  bit feed_on = 0, stray = 0;

  function automatic logic [AW-1:0] taddr(int t);
    logic [31:0] t32 = t;
    return 32'h100 + (t32 << 2);
  endfunction
  function automatic logic [SW-1:0] tx(int t);
    logic [31:0] t32 = t;
    return {32'hC0DE_0000 + t32, taddr(t)};
  endfunction
  function automatic logic [MD-1:0] mdat(logic [AW-1:0] a);
    return a ^ 32'hDEAD_0000;
  endfunction
  function automatic logic [OW-1:0] rsp(int t);
    return {mdat(taddr(t)), tx(t)};
  endfunction

  task automatic chk(string name, logic [127:0] act, logic [127:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Sample settled signals, advance one clock, then drive memory and feeder for the new cycle.
  task automatic tick();
    bit hs;
    #1;
    if (mem_req && mem_gnt) mq.push_back('{addr: mem_addr, due: cyc + lat});
    if (master_valid && master_ready) obs_q.push_back(master_data);
    hs = slave_valid && slave_ready && rst_ni;
    @(posedge clk_i);
    @(negedge clk_i);
    cyc++;
    if (!rst_ni) mq.delete();
    if (feed_on) begin
      if (hs) begin feed_left--; next_tag++; end
      slave_valid = (feed_left > 0);
      slave_data  = tx(next_tag);
    end
    mem_valid = 1'b0;
    mem_rdata = '0;
    if (stray) begin
      mem_valid = 1'b1; mem_rdata = 32'hBAD0_BAD0; stray = 0;
    end else if (mq.size() > 0 && mq[0].due <= cyc) begin
      mem_valid = 1'b1; mem_rdata = mdat(mq[0].addr); void'(mq.pop_front());
    end
    #1;
  endtask

  task automatic check_stream(string name);
    chk({name, "_count"}, obs_q.size(), exp_q.size());
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) chk({name, "_data"}, obs_q[i], exp_q[i]);
    obs_q.delete(); exp_q.delete();
  endtask

  task automatic drain(int n);
    for (int k = 0; k < 40 && obs_q.size() < n; k++) tick();
    for (int k = 0; k < 4; k++) tick();
  endtask

  task automatic do_reset();
    feed_on = 0; slave_valid = 0; flush_i = 0; stall_i = 0; mem_gnt = 1; master_ready = 1;
    rst_ni = 0;
    tick();
    rst_ni = 1;
    obs_q.delete(); exp_q.delete();
  endtask

  task automatic start_feed(int first, int n);
    next_tag = first; feed_left = n; feed_on = 1;
    slave_valid = 1; slave_data = tx(first);
  endtask

  vec_t vec [11];
  logic [14:0] credit_pat;

  initial begin
    rst_ni = 0; stall_i = 0; flush_i = 0; slave_valid = 0; slave_data = '0;
    mem_gnt = 1; master_ready = 1; mem_valid = 0; mem_rdata = '0;
    tick(); tick();
    rst_ni = 1; #1;
    chk("rst_sready", slave_ready, 1); chk("rst_req", mem_req, 0);
    chk("rst_addr", mem_addr, 0);     chk("rst_mvalid", master_valid, 0);
    chk("rst_mdata", master_data, 0); chk("rst_we", mem_we, 0);
    chk("rst_be", mem_be, 0);         chk("rst_wdata", mem_wdata, 0);

    // Back-to-back, latency 1: output of tag c-2 in cycle c.
    vec[0] = '{1, 0, 1, 0, '0, 0, '0};
    vec[1] = '{1, 1, 1, 1, taddr(0), 0, '0};
    for (int c = 2; c <= 7; c++) vec[c] = '{1, c, 1, 1, taddr(c-1), 1, rsp(c-2)};
    vec[8]  = '{0, 8, 1, 1, taddr(7), 1, rsp(6)};
    vec[9]  = '{0, 8, 1, 0, '0, 1, rsp(7)};
    vec[10] = '{0, 8, 1, 0, '0, 0, '0};
    lat = 1;
    for (int c = 0; c < 11; c++) begin
      slave_valid = vec[c].in_valid; slave_data = tx(vec[c].in_tag);
      #1;
      chk($sformatf("b2b_sready_c%0d", c), slave_ready, vec[c].sready);
      chk($sformatf("b2b_req_c%0d", c), mem_req, vec[c].req);
      if (vec[c].req) chk($sformatf("b2b_addr_c%0d", c), mem_addr, vec[c].addr);
      chk($sformatf("b2b_mvalid_c%0d", c), master_valid, vec[c].mvalid);
      if (vec[c].mvalid) chk($sformatf("b2b_mdata_c%0d", c), master_data, vec[c].mdata);
      tick();
    end
    for (int i = 0; i < 8; i++) exp_q.push_back(rsp(i));
    check_stream("b2b_stream");

    // Credit limit, latency 10.
    do_reset(); lat = 10;
    credit_pat = 15'b011_0000_0001_1110;
    start_feed(0, 6);
    for (int c = 0; c < 15; c++) begin
      #1; chk($sformatf("credit_req_c%0d", c), mem_req, credit_pat[c]);
      tick();
    end
    drain(6);
    for (int i = 0; i < 6; i++) exp_q.push_back(rsp(i));
    check_stream("credit_stream");

    // Backpressure, latency 2: four responses buffered while ready=0.
    do_reset(); lat = 2; master_ready = 0;
    start_feed(0, 6);
    for (int c = 0; c < 7; c++) begin
      if (c == 5) begin #1; chk("bp_req_full", mem_req, 0); end
      tick();
    end
    #1;
    chk("bp_mvalid", master_valid, 1); chk("bp_mdata", master_data, rsp(0)); chk("bp_req_held", mem_req, 0);
    tick();
    master_ready = 1; #1;
    chk("bp_req_pop_cycle", mem_req, 0);
    tick(); #1;
    chk("bp_req_resume", mem_req, 1);
    drain(6);
    for (int i = 0; i < 6; i++) exp_q.push_back(rsp(i));
    check_stream("bp_stream");

    // Flush with 3 in flight and 1 buffered.
    do_reset(); lat = 5; master_ready = 0;
    start_feed(0, 4);
    tick();                                  // c0
    tick();                                  // c1: issue T0
    mem_gnt = 0; #1;
    chk("fl_wait_req", mem_req, 1); chk("fl_wait_addr0", mem_addr, taddr(1));
    tick();                                  // c2
    #1; chk("fl_wait_addr1", mem_addr, taddr(1));
    tick();                                  // c3
    mem_gnt = 1;
    tick(); tick(); tick();                  // c4..c6: issue T1..T3, T0 buffered
    #1; chk("fl_pre_mvalid", master_valid, 1);
    flush_i = 1; #1;
    chk("fl_mvalid", master_valid, 0); chk("fl_sready", slave_ready, 0); chk("fl_req", mem_req, 0);
    tick();
    flush_i = 0; master_ready = 1;
    start_feed(20, 1); #1;
    chk("fl_after_mvalid", master_valid, 0);
    tick(); #1;
    chk("fl_a_req", mem_req, 1); chk("fl_a_addr", mem_addr, taddr(20));
    drain(1);
    exp_q.push_back(rsp(20));
    check_stream("fl_stream");

    // Stall for 5 cycles with a loaded request register.
    do_reset(); lat = 3;
    start_feed(0, 3);
    tick(); tick();
    stall_i = 1;
    for (int c = 2; c <= 6; c++) begin
      #1;
      chk($sformatf("st_req_c%0d", c), mem_req, 0);
      chk($sformatf("st_addr_c%0d", c), mem_addr, taddr(1));
      if (c == 4) begin chk("st_mvalid", master_valid, 1); chk("st_mdata", master_data, rsp(0)); end
      tick();
    end
    stall_i = 0; #1;
    chk("st_resume_req", mem_req, 1); chk("st_resume_addr", mem_addr, taddr(1));
    drain(3);
    for (int i = 0; i < 3; i++) exp_q.push_back(rsp(i));
    check_stream("st_stream");

    // Reset with 2 in flight; a late response must be ignored.
    do_reset(); lat = 4;
    start_feed(0, 2);
    tick(); tick(); tick();
    feed_on = 0; slave_valid = 0; rst_ni = 0;
    tick();
    rst_ni = 1; #1;
    chk("mr_req", mem_req, 0); chk("mr_mvalid", master_valid, 0); chk("mr_sready", slave_ready, 1);
    chk("mr_addr", mem_addr, 0); chk("mr_mdata", master_data, 0);
    stray = 1;
    tick(); #1;
    chk("mr_stray_mvalid", master_valid, 0);
    tick();
    start_feed(30, 1);
    drain(1);
    exp_q.push_back(rsp(30));
    check_stream("mr_stream");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/memory_read_pipe.md
Name: memory_read_pipe

Overview:
Parametrised successor of the SRAM read stage in the walker pipeline. It accepts transactions on a pipeline slave port and issues SRAM reads for them, with up to MAX_OUTSTANDING reads in flight. It returns responses in order as {rdata, context} on a pipeline master port. New over the previous stage: credit-based flow control, a configurable address field, stall and flush with drop-on-return of in-flight reads, and a response buffer sized to the credit limit.

Parameters:
PIPELINE_SLAVE_DATA_WIDTH, 64, width of the incoming transaction (context).
MEMORY_DATA_WIDTH, 32, SRAM read data width.
MEMORY_ADDR_WIDTH, 32, SRAM address width.
ADDR_OFFSET, 0, LSB position of the address field in stage_slave_data.
MAX_OUTSTANDING, 4, credit limit (>=1): reads in flight plus buffered responses.
PIPELINE_MASTER_DATA_WIDTH, MEMORY_DATA_WIDTH+PIPELINE_SLAVE_DATA_WIDTH, output payload width (derived, do not override).

Ports:
clk_i  in  1  clock; all state on rising edge
rst_ni  in  1  reset, synchronous, active-low
stall_i  in  1  blocks issue of new reads
flush_i  in  1  drops pending, buffered and in-flight transactions
stage_slave_data  in  PIPELINE_SLAVE_DATA_WIDTH  incoming transaction
stage_slave_valid  in  1  transaction valid
stage_slave_ready  out  1  request register can accept
stage_master_data  out  PIPELINE_MASTER_DATA_WIDTH  {rdata, context}
stage_master_valid  out  1  response valid
stage_master_ready  in  1  downstream accepts
memory_master_mem_req  out  1  SRAM request
memory_master_mem_gnt  in  1  SRAM grant
memory_master_mem_addr  out  MEMORY_ADDR_WIDTH  read address
memory_master_mem_we  out  1  tied 0
memory_master_mem_be  out  MEMORY_DATA_WIDTH/8  tied 0
memory_master_mem_wdata  out  MEMORY_DATA_WIDTH  tied 0
memory_master_mem_valid  in  1  read data valid (in order, no backpressure)
memory_master_mem_rdata  in  MEMORY_DATA_WIDTH  read data

Behaviour:
- Reset (rst_ni=0 at clk edge): request register empty, inflight=0, drop_cnt=0, response FIFO empty. Outputs: mem_req=0, stage_master_valid=0, stage_slave_ready=1, mem_addr=0, stage_master_data=0. Reset mid-operation discards everything; responses arriving after reset are ignored (drop_cnt=0, credits=0). The memory side is reset together with this block.
- Request register (1 entry): loaded on slave valid&&ready. stage_slave_ready = empty || (mem_req && mem_gnt) (pass-through refill, full throughput).
- used = inflight + fifo_count. Both are counters of width $clog2(MAX_OUTSTANDING+1).
- mem_req = reg_valid && !stall_i && !flush_i && (used < MAX_OUTSTANDING). Same-cycle pops do not free a credit until the next cycle.
- mem_addr = reg_data[ADDR_OFFSET +: MEMORY_ADDR_WIDTH], held stable while mem_req=1 and gnt=0.
- On req&&gnt: the context is pushed into the context FIFO (depth MAX_OUTSTANDING) and inflight increments.
- On mem_valid: inflight decrements and the context FIFO pops.
  - If drop_cnt>0: the response is discarded and drop_cnt decrements.
  - Else, if the response FIFO is empty and stage_master_ready=1: bypass. stage_master_valid=1 in the same cycle, data={rdata, ctx}, zero latency.
  - Else: {rdata, ctx} is pushed into the response FIFO (depth MAX_OUTSTANDING). Credits guarantee it never overflows; an overflow is an assertion failure.
- Output: when the response FIFO is non-empty it drives stage_master_valid/data; pop on valid&&ready. Order is strictly the issue order.
- Simultaneous gnt and valid in the same cycle: inflight is unchanged; context FIFO push and pop both occur.
- stall_i: only blocks new issue. Responses still return and drain.
- flush_i (one cycle, highest priority):
  - request register cleared; mem_req forced 0 that cycle.
  - response FIFO cleared; stage_master_valid=0 that cycle.
  - drop_cnt <= inflight - (mem_valid ? 1 : 0), i.e. every read still outstanding after this cycle.
  - A response arriving in the flush cycle itself is discarded.
  - Slave handshake in the flush cycle is ignored (stage_slave_ready=0).
  - Issue may resume the next cycle; new responses follow the dropped ones in order.
- Counters never wrap. inflight, used and drop_cnt are all bounded by MAX_OUTSTANDING; assertions check this.

Optional Feature:
MEMORY_READ_PIPE_PERF_CNT_EN:
- Defined: adds outputs perf_issued_o[31:0] (count of req&&gnt), perf_credit_stall_o[31:0] (cycles with reg_valid && used==MAX_OUTSTANDING) and perf_dropped_o[31:0] (responses discarded). All three clear on reset and saturate at 0xFFFFFFFF.
- Undefined: these ports and counters do not exist.

Test Plan:
- Back-to-back: 8 transactions, gnt always 1, 1-cycle read latency, ready=1, addr field 0x100+4i -> 8 outputs, one per cycle after the first, rdata/context matching in order, no bubbles.
- Credit limit: MAX_OUTSTANDING=4, gnt=1, read latency 10 -> exactly 4 reads issued, mem_req=0 until the first mem_valid, then 1 new issue per returned response.
- Backpressure: ready=0 while 4 responses return -> all 4 buffered, mem_req=0. Ready raised -> 4 outputs in order, then issue resumes.
- Flush: 3 reads in flight, 1 buffered, flush_i pulsed -> master_valid=0, 3 subsequent mem_valid discarded (drop_cnt 3->0), new transaction A issued next cycle, and A's response is the first output.
- Stall: stall_i=1 for 5 cycles with reg_valid=1 -> mem_req=0 for those cycles, mem_addr stable, in-flight responses still output. stall_i=0 -> issue on the next cycle.
- Reset mid-operation: rst_ni=0 with 2 in flight -> all outputs at reset values, late mem_valid ignored, first post-reset transaction returns correct data.
